// File: rtl/redundancy_compactor_pkg.sv
// Shared types and constants for the redundancy compactor: FSM state
// encoding and the reserved map index used for skipped all-zero columns.
package rc_pkg;

    // Controller states. IDLE accepts a column, COMPARE walks the table,
    // EMIT holds one output beat until the consumer takes it.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_EMIT    = 2'd2
    } rc_state_e;

    // Widest supported index; the reserved "zero column" index is all-ones
    // and each instance slices the low IDX_WIDTH bits.
    localparam int unsigned MAX_IDX_WIDTH = 32;
    localparam logic [MAX_IDX_WIDTH-1:0] ZERO_IDX = '1;

endpackage

// File: rtl/redundancy_compactor_if.sv
// Column stream interface for the redundancy compactor: one input column
// channel and one output beat channel, plus the frame-level skip mode.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The sender holds valid and its payload stable until that
// edge; ready may change freely and does not depend on valid combinationally.
interface redundancy_compactor_if #(
    parameter int WORD_WIDTH = 8,
    parameter int COL_WORDS  = 128,
    parameter int IDX_WIDTH  = 8
);
    localparam int COL_W = WORD_WIDTH * COL_WORDS;

    // input column channel
    logic             in_valid;
    logic             in_ready;
    logic [COL_W-1:0] in_column;
    logic             in_last;
    // held stable for a whole frame
    logic             cfg_zero_skip;

    // output beat channel
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_unique;
    logic [COL_W-1:0]     out_column;
    logic [IDX_WIDTH-1:0] out_map_idx;
    logic                 out_last;
    logic                 out_overflow;

    // compactor side
    modport slave (
        input  in_valid, in_column, in_last, cfg_zero_skip, out_ready,
        output in_ready, out_valid, out_unique, out_column, out_map_idx,
               out_last, out_overflow
    );

    // producer/consumer side
    modport master (
        output in_valid, in_column, in_last, cfg_zero_skip, out_ready,
        input  in_ready, out_valid, out_unique, out_column, out_map_idx,
               out_last, out_overflow
    );

endinterface

// File: rtl/redundancy_compactor_table.sv
// Unique-column table: DEPTH stored {column, dense index} pairs filled in
// order, an occupancy count, one append port and one indexed compare port.
module rc_column_table #(
    parameter int COL_W     = 1024,
    parameter int DEPTH     = 8,
    parameter int IDX_WIDTH = 8,
    parameter int OCC_W     = $clog2(DEPTH + 1),
    parameter int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [COL_W-1:0]     wr_column,
    input  logic [IDX_WIDTH-1:0] wr_idx,
    input  logic [PTR_W-1:0]     rd_ptr,
    input  logic [COL_W-1:0]     cmp_column,
    output logic                 match,
    output logic [IDX_WIDTH-1:0] rd_idx,
    output logic [OCC_W-1:0]     occupancy,
    output logic                 full
);
    logic [COL_W-1:0]     cols [DEPTH];
    logic [IDX_WIDTH-1:0] idxs [DEPTH];

    assign full   = (occupancy == OCC_W'(DEPTH));
    assign match  = (cols[rd_ptr] == cmp_column);
    assign rd_idx = idxs[rd_ptr];

    // Occupancy: frame end clears it and wins over a same-edge append;
    // appends to a full table are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else if (clear) begin
            occupancy <= '0;
        end else if (wr_en && !full) begin
            occupancy <= occupancy + OCC_W'(1);
        end
    end

    // Entry storage: only slots below occupancy are ever read, so the
    // payload needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !full && !clear) begin
            cols[PTR_W'(occupancy)] <= wr_column;
            idxs[PTR_W'(occupancy)] <= wr_idx;
        end
    end

endmodule

// File: rtl/redundancy_compactor.sv
// Redundancy compactor: deduplicates LIFM columns within a frame. Each new
// column is compared against previously seen unique columns (one per
// cycle); repeats are emitted with the index of their first occurrence,
// new columns get the next dense index and are remembered while the table
// has room. All-zero columns can be skipped with a reserved index.
module redundancy_compactor
    import rc_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int COL_WORDS  = 128,
    parameter int DEPTH      = 8,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    redundancy_compactor_if.slave  bus,
    output logic [1:0]             state_dbg
);
    localparam int COL_W = WORD_WIDTH * COL_WORDS;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_WIDTH-1:0] ZERO_IDX_W = ZERO_IDX[IDX_WIDTH-1:0];
    localparam logic [IDX_WIDTH-1:0] DENSE_MAX  = ZERO_IDX_W - IDX_WIDTH'(1);

    rc_state_e            state;
    logic [COL_W-1:0]     cap_column;
    logic                 cap_last;
    logic [PTR_W-1:0]     cursor;
    logic                 unique_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic                 ovf_q;
    logic [IDX_WIDTH-1:0] dense_cnt;

    logic                 tbl_match;
    logic [IDX_WIDTH-1:0] tbl_idx;
    logic [OCC_W-1:0]     occupancy;
    logic                 tbl_full;
    logic                 accept;
    logic                 last_entry;
    logic                 in_zero;

    assign accept     = (state == ST_EMIT) && bus.out_ready;
    assign last_entry = (OCC_W'(cursor) == (occupancy - OCC_W'(1)));
    assign in_zero    = (bus.in_column == '0);

    assign bus.in_ready     = (state == ST_IDLE);
    assign bus.out_valid    = (state == ST_EMIT);
    assign bus.out_unique   = unique_q;
    assign bus.out_column   = cap_column;
    assign bus.out_map_idx  = idx_q;
    assign bus.out_last     = cap_last;
    assign bus.out_overflow = ovf_q;
    assign state_dbg        = state;

    rc_column_table #(
        .COL_W     (COL_W),
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IDX_WIDTH),
        .OCC_W     (OCC_W),
        .PTR_W     (PTR_W)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept && cap_last),
        .wr_en      (accept && unique_q),
        .wr_column  (cap_column),
        .wr_idx     (dense_cnt),
        .rd_ptr     (cursor),
        .cmp_column (cap_column),
        .match      (tbl_match),
        .rd_idx     (tbl_idx),
        .occupancy  (occupancy),
        .full       (tbl_full)
    );

    // Control FSM: capture a column, walk the table, then hold the beat.
    // The output fields are settled on entry to EMIT and never change there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cap_column <= '0;
            cap_last   <= 1'b0;
            cursor     <= '0;
            unique_q   <= 1'b0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        cap_column <= bus.in_column;
                        cap_last   <= bus.in_last;
                        cursor     <= '0;
                        if (bus.cfg_zero_skip && in_zero) begin
                            unique_q <= 1'b0;
                            idx_q    <= ZERO_IDX_W;
                            ovf_q    <= 1'b0;
                            state    <= ST_EMIT;
                        end else if (occupancy != '0) begin
                            state <= ST_COMPARE;
                        end else begin
                            unique_q <= 1'b1;
                            idx_q    <= dense_cnt;
                            ovf_q    <= tbl_full;
                            state    <= ST_EMIT;
                        end
                    end
                end
                ST_COMPARE: begin
                    if (tbl_match) begin
                        unique_q <= 1'b0;
                        idx_q    <= tbl_idx;
                        ovf_q    <= 1'b0;
                        state    <= ST_EMIT;
                    end else if (last_entry) begin
                        unique_q <= 1'b1;
                        idx_q    <= dense_cnt;
                        ovf_q    <= tbl_full;
                        state    <= ST_EMIT;
                    end else begin
                        cursor <= cursor + PTR_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Dense index counter: advances once per accepted unique beat,
    // saturates below the reserved zero index, restarts at frame end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dense_cnt <= '0;
        end else if (accept) begin
            if (cap_last) begin
                dense_cnt <= '0;
            end else if (unique_q && (dense_cnt != DENSE_MAX)) begin
                dense_cnt <= dense_cnt + IDX_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_redundancy_compactor.sv
// Directed bench for redundancy_compactor with COL_WORDS=4, DEPTH=4.
// Stimulus pushes hand-computed beats into exp_q; a monitor pops and
// compares each beat as the DUT hands it over.
module tb_redundancy_compactor;
    localparam int WW   = 8;
    localparam int CW   = 4;
    localparam int DP   = 4;
    localparam int IW   = 8;
    localparam int COLW = WW * CW;
    localparam int EW   = 1 + COLW + IW + 1 + 1;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         total;
    int         bad;
    logic [EW-1:0] exp_q[$];

    redundancy_compactor_if #(.WORD_WIDTH(WW), .COL_WORDS(CW), .IDX_WIDTH(IW)) bus ();

    redundancy_compactor #(
        .WORD_WIDTH (WW),
        .COL_WORDS  (CW),
        .DEPTH      (DP),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            got = {bus.out_unique, bus.out_column, bus.out_map_idx, bus.out_last, bus.out_overflow};
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(got), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat", 64'(got), 64'(e));
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [COLW-1:0] col, input logic last, input logic u,
                         input logic [IW-1:0] idx, input logic ovf, input bit expect_beat);
        if (expect_beat) exp_q.push_back({u, col, idx, last, ovf});
        bus.in_valid  = 1'b1;
        bus.in_column = col;
        bus.in_last   = last;
    endtask

    task automatic wait_accept(input string name);
        int   n;
        logic taken;
        n = 0;
        taken = 1'b0;
        while (!taken && n < 200) begin
            @(negedge clk);
            taken = bus.in_ready && bus.in_valid;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check({"accept_", name}, 64'(taken), 64'd1);
    endtask

    task automatic send(input string name, input logic [COLW-1:0] col, input logic last,
                        input logic u, input logic [IW-1:0] idx, input logic ovf);
        issue(col, last, u, idx, ovf, 1'b1);
        wait_accept(name);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    localparam logic [COLW-1:0] COL_A  = 32'h1122_3344;
    localparam logic [COLW-1:0] COL_B  = 32'hA5A5_0001;
    localparam logic [COLW-1:0] COL_C  = 32'h0F0F_F0F0;
    localparam logic [COLW-1:0] COL_E  = 32'hDEAD_BEEF;
    localparam logic [COLW-1:0] COL_F  = 32'h0000_0100;

    // stimulus
    initial begin
        logic [COLW-1:0] d [5];
        total = 0;
        bad   = 0;
        d[0] = 32'h0102_0304;
        d[1] = 32'h0506_0708;
        d[2] = 32'h090A_0B0C;
        d[3] = 32'h0D0E_0F10;
        d[4] = 32'h1112_1314;

        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_column     = '0;
        bus.in_last       = 1'b0;
        bus.cfg_zero_skip = 1'b0;
        bus.out_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_unique", 64'(bus.out_unique), 64'd0);
        check("rst_out_column", 64'(bus.out_column), 64'd0);
        check("rst_out_map_idx", 64'(bus.out_map_idx), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_overflow", 64'(bus.out_overflow), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // frame A,B,A,C(last)
        send("s1_a", COL_A, 1'b0, 1'b1, 8'd0, 1'b0);
        send("s1_b", COL_B, 1'b0, 1'b1, 8'd1, 1'b0);
        send("s1_a2", COL_A, 1'b0, 1'b0, 8'd0, 1'b0);
        send("s1_c", COL_C, 1'b1, 1'b1, 8'd2, 1'b0);
        drain();

        // zero-column skip, then zero column treated as data
        bus.cfg_zero_skip = 1'b1;
        send("s2_zero", '0, 1'b0, 1'b0, 8'hFF, 1'b0);
        check("s2_zero_latency", 64'(bus.out_valid), 64'd1);
        send("s2_zero_last", '0, 1'b1, 1'b0, 8'hFF, 1'b0);
        drain();
        bus.cfg_zero_skip = 1'b0;
        send("s2_zero_data", '0, 1'b1, 1'b1, 8'd0, 1'b0);
        drain();

        // table overflow: fifth distinct column and its repeat
        for (int i = 0; i < 4; i++) begin
            send("s3_fill", d[i], 1'b0, 1'b1, IW'(i), 1'b0);
        end
        send("s3_over", d[4], 1'b0, 1'b1, 8'd4, 1'b1);
        send("s3_over_rep", d[4], 1'b1, 1'b1, 8'd5, 1'b1);
        drain();

        // consumer stall in EMIT with a column waiting at the input
        bus.out_ready = 1'b0;
        send("s4_e", COL_E, 1'b0, 1'b1, 8'd0, 1'b0);
        issue(COL_F, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("s4_out_valid", 64'(bus.out_valid), 64'd1);
            check("s4_out_column", 64'(bus.out_column), 64'(COL_E));
            check("s4_out_map_idx", 64'(bus.out_map_idx), 64'd0);
            check("s4_out_unique", 64'(bus.out_unique), 64'd1);
            check("s4_in_ready", 64'(bus.in_ready), 64'd0);
            check("s4_state", 64'(state_dbg), 64'd2);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept("s4_f");
        drain();

        // table contents do not carry across frames
        send("s5_f1", COL_A, 1'b1, 1'b1, 8'd0, 1'b0);
        send("s5_f2", COL_A, 1'b1, 1'b1, 8'd0, 1'b0);
        drain();

        // reset while comparing abandons the beat
        send("s6_b", COL_B, 1'b0, 1'b1, 8'd0, 1'b0);
        send("s6_d", d[0], 1'b0, 1'b1, 8'd1, 1'b0);
        issue(COL_C, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        wait_accept("s6_c");
        check("s6_in_compare", 64'(state_dbg), 64'd1);
        rst = 1'b1;
        #1;
        check("s6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("s6_rst_out_column", 64'(bus.out_column), 64'd0);
        check("s6_rst_out_map_idx", 64'(bus.out_map_idx), 64'd0);
        check("s6_rst_out_unique", 64'(bus.out_unique), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("s6_no_beat", 64'(bus.out_valid), 64'd0);
        send("s6_a", COL_A, 1'b1, 1'b1, 8'd0, 1'b0);
        drain();

        // final report
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
